// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce_gen switch-bounce emulator.
package bounce_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GLITCH_NEW,
    GLITCH_OLD,
    SETTLE,
    DONE
  } state_t;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  // One Galois shift: output bit 0 folds the polynomial back into the register.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr.sv
// 16-bit Galois LFSR that advances one step whenever step_i is high.
module bounce_gen_lfsr
  import bounce_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_o <= SEED;
    end else if (step_i) begin
      lfsr_o <= lfsr_next(lfsr_o);
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// Emulated bouncy switch: glitch pairs between old/new level, then a settle hold.
// BOUNCE_GEN_RAND_EN selects LFSR-randomised phase delays; otherwise every delay is the maximum.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int unsigned MIN_DELAY     = 1,
  parameter int unsigned DW            = 4,
  parameter int unsigned NUM_BOUNCES   = 3,
  parameter int unsigned SETTLE_CYCLES = 30,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic level_i,
  output logic sw_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned CW        = (DW + 8 > 16) ? DW + 8 : 16;
  localparam int unsigned MAX_DELAY = MIN_DELAY + 2**DW - 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [8:0]    pair_cnt;
  logic          target;
  logic [DW+7:0] delay;

`ifdef BOUNCE_GEN_RAND_EN
  logic [LFSR_W-1:0] lfsr_val;
  logic              load_delay;

  bounce_gen_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (load_delay),
    .lfsr_o (lfsr_val)
  );

  assign delay = (DW+8)'(MIN_DELAY) + {8'd0, lfsr_val[DW-1:0]};

  // Mirrors every point in the FSM where a phase delay is loaded into cnt.
  always_comb begin
    load_delay = 1'b0;
    case (state)
      IDLE:       load_delay = start_i && (level_i != sw_o) && (NUM_BOUNCES > 0);
      GLITCH_NEW: load_delay = (cnt == '0);
      GLITCH_OLD: load_delay = (cnt == '0) && ((pair_cnt + 9'd1) < 9'(NUM_BOUNCES));
      default:    load_delay = 1'b0;
    endcase
  end
`else
  assign delay = (DW+8)'(MAX_DELAY);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      sw_o     <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      cnt      <= '0;
      pair_cnt <= '0;
      target   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            target <= level_i;
            if (level_i != sw_o) begin
              sw_o     <= level_i;
              busy_o   <= 1'b1;
              pair_cnt <= '0;
              if (NUM_BOUNCES > 0) begin
                state <= GLITCH_NEW;
                cnt   <= CW'(delay) - CW'(1);
              end else begin
                state <= SETTLE;
                cnt   <= CW'(SETTLE_CYCLES - 1);
              end
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        GLITCH_NEW: begin
          if (cnt == '0) begin
            state <= GLITCH_OLD;
            sw_o  <= ~target;
            cnt   <= CW'(delay) - CW'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GLITCH_OLD: begin
          if (cnt == '0) begin
            pair_cnt <= pair_cnt + 9'd1;
            sw_o     <= target;
            if ((pair_cnt + 9'd1) < 9'(NUM_BOUNCES)) begin
              state <= GLITCH_NEW;
              cnt   <= CW'(delay) - CW'(1);
            end else begin
              state <= SETTLE;
              cnt   <= CW'(SETTLE_CYCLES - 1);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: whole expected sw/busy/done waveforms are queued per request.
module tb_bounce_gen;

  localparam int NB     = 3;
  localparam int SET    = 30;
  localparam int MIN_D  = 1;
  localparam int SPAN   = 16;
  localparam logic [15:0] SEED_V = 16'hACE1;

  typedef logic [2:0] exp_t;  // {sw, busy, done}

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic level_i = 1'b0;
  logic sw_o, busy_o, done_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t exp_q[$];

  logic        model_sw;
  logic [15:0] model_lfsr;

  bounce_gen #(
    .MIN_DELAY     (MIN_D),
    .DW            (4),
    .NUM_BOUNCES   (NB),
    .SETTLE_CYCLES (SET),
    .SEED          (SEED_V)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .level_i (level_i),
    .sw_o    (sw_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expected triple per cycle while the scoreboard holds entries.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({sw_o, busy_o, done_o} !== e)
        begin
          bad++;
          $display("FAIL outputs cyc=%0d sw,busy,done got=%b%b%b want=%b%b%b",
                   cyc, sw_o, busy_o, done_o, e[2], e[1], e[0]);
        end
    end
  end

  function automatic int next_delay();
    int d;
`ifdef BOUNCE_GEN_RAND_EN
    d = MIN_D + int'(model_lfsr % 16);
    model_lfsr = (model_lfsr >> 1) ^ ((model_lfsr & 16'h1) != 0 ? 16'hB400 : 16'h0);
`else
    d = MIN_D + SPAN - 1;
`endif
    return d;
  endfunction

  task automatic reset_pulse();
    rst_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(3'b000);
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_sw = 1'b0;
    model_lfsr = SEED_V;
  endtask

  // Request a transition to lv; optionally poke start during busy, or reset after cut cycles.
  task automatic issue(input logic lv, input bit pulse, input int gap, input int cut);
    exp_t w[$];
    int d, busy_len, pulse_at, n_cut, len;
    w.push_back({model_sw, 2'b00});
    if (lv != model_sw) begin
      for (int p = 0; p < NB; p++) begin
        d = next_delay();
        repeat (d) w.push_back({lv, 2'b10});
        d = next_delay();
        repeat (d) w.push_back({~lv, 2'b10});
      end
      repeat (SET) w.push_back({lv, 2'b10});
    end
    busy_len = w.size() - 1;
    w.push_back({lv, 2'b01});
    repeat (gap) w.push_back({lv, 2'b00});
    model_sw = lv;
    n_cut = (cut > busy_len) ? busy_len : cut;
    if (cut > 0)
      while (w.size() > n_cut + 1) void'(w.pop_back());
    foreach (w[i]) exp_q.push_back(w[i]);
    len = w.size();
    pulse_at = (pulse && cut == 0) ? int'($urandom_range(busy_len + 1, 1)) : -1;
    start_i = 1'b1;
    level_i = lv;
    if (cut > 0) begin
      for (int c = 1; c <= n_cut; c++) begin
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      reset_pulse();
    end else begin
      for (int c = 1; c <= len; c++) begin
        @(posedge clk); #1;
        start_i = (c == pulse_at);
        if (start_i) level_i = 1'($urandom);
      end
    end
  endtask

  initial begin
    model_sw = 1'b0;
    model_lfsr = SEED_V;
    reset_pulse();
    issue(1'b1, 1'b0, 2, 0);   // full rising transition, done at cycle 126 in fixed build
    issue(1'b1, 1'b0, 2, 0);   // same level: immediate done, no sw change
    issue(1'b1, 1'b1, 1, 0);   // same level with start held into DONE
    issue(1'b0, 1'b1, 2, 0);   // falling with an ignored start mid-transition
    issue(1'b1, 1'b1, 2, 0);   // rising with an ignored start
    issue(1'b0, 1'b0, 1, 0);
    issue(1'b1, 1'b0, 0, 40);  // reset mid-transition
    issue(1'b1, 1'b0, 2, 0);   // recovery after abort
    for (int t = 0; t < 50; t++)
      issue(1'($urandom), 1'(($urandom % 3) == 0), int'($urandom_range(3, 0)), 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0)
      $display("FAIL scoreboard not drained queue_left=%0d want=0", exp_q.size());
    if (total == 0)
      $display("FAIL no cycles checked total=%0d", total);
    if (bad != 0)
      $display("FAIL mismatches bad=%0d want=0", bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d queue_left=%0d want=0", cyc, exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameters (name, default, meaning):
- MIN_DELAY, 1, shortest bounce phase in cycles.
- DW, 4, delay width; MAX delay = MIN_DELAY + 2**DW - 1.
- NUM_BOUNCES, 3, glitch pairs per transition, range 0..255.
- SETTLE_CYCLES, 30, final stable hold in cycles, 1..65535.
- SEED, 16'hACE1, LFSR seed; nonzero.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, request a switch transition.
- level_i, in, 1, target switch level, sampled with start_i.
- sw_o, out, 1, emulated bouncy switch, to feed a debouncer sw_i.
- busy_o, out, 1, transition in progress.
- done_o, out, 1, one-cycle pulse when a transition is complete.

Function
REQ-004 The block SHALL implement FSM states IDLE, GLITCH_NEW, GLITCH_OLD, SETTLE and DONE.
REQ-005 In IDLE, sw_o SHALL hold its last settled level, and busy_o SHALL be 0.
REQ-006 When start_i=1 at a clock edge in IDLE with level_i != sw_o, the request SHALL be accepted: sw_o=level_i and busy_o=1 from that edge.
- If NUM_BOUNCES>0, the state becomes GLITCH_NEW with a loaded delay.
- Otherwise, the state becomes SETTLE.
REQ-007 GLITCH_NEW SHALL drive level_i for exactly D cycles, then go to GLITCH_OLD. GLITCH_OLD SHALL drive the old level for exactly D' cycles. D and D' are freshly loaded delays.
REQ-008 After GLITCH_OLD, the pair counter SHALL increment.
- If count < NUM_BOUNCES, the state returns to GLITCH_NEW.
- Otherwise, the state goes to SETTLE.
REQ-009 SETTLE SHALL drive level_i for exactly SETTLE_CYCLES cycles, then go to DONE.
REQ-010 DONE SHALL last one cycle with done_o=1, busy_o=0 and sw_o=level_i, then return to IDLE.
REQ-011 A start_i with level_i == sw_o in IDLE SHALL go directly to DONE: one done_o pulse on the next cycle, no sw_o change.
REQ-012 start_i SHALL be ignored outside IDLE, including in DONE; level_i SHALL be latched at acceptance only.
REQ-013 Delay load SHALL be delay = MIN_DELAY + lfsr[DW-1:0], computed with width DW+8 and no overflow.
REQ-014 The phase counter SHALL count down from delay-1 to 0, so a phase lasts exactly delay cycles.
REQ-015 The LFSR SHALL be a 16-bit Galois LFSR with polynomial 16'hB400, advanced exactly once per delay load.
REQ-016 Total busy duration SHALL be the sum of the 2*NUM_BOUNCES phase delays plus SETTLE_CYCLES cycles.

Reset
REQ-017 While rst_i=1 at a clock edge, the block SHALL be reset: state IDLE, sw_o=0, busy_o=0, done_o=0, counters 0, LFSR=SEED.
REQ-018 Reset asserted mid-transition SHALL abort the transition and apply REQ-017 on that edge; no done_o is produced.

Configuration
REQ-019 Macro BOUNCE_GEN_RAND_EN SHALL select the delay source.
- Defined: delays per REQ-013.
- Undefined: every delay = MIN_DELAY + 2**DW - 1 (fixed maximum), and no LFSR is instantiated.
- Cycle timing otherwise SHALL be identical in both builds.

Structure
REQ-020 A package bounce_gen_pkg SHALL hold the FSM state enum, the LFSR width (16) and the polynomial constant.
REQ-021 The LFSR SHALL be a sub-module bounce_gen_lfsr with ports clk_i, rst_i, step_i and a 16-bit value output; it is instantiated only under BOUNCE_GEN_RAND_EN.

Verification
REQ-022 Scenarios (macro undefined, defaults, so D=16):
- Reset (rst_i=1 for 2 cycles) -> sw_o=0, busy_o=0, done_o=0.
- start_i=1, level_i=1 at edge 0 -> sw_o=1 for cycles 0-15 and 0 for cycles 16-31, repeated 3 times; then sw_o=1 for cycles 96-125; done_o=1 at cycle 126 only.
- start_i=1, level_i=1 while sw_o=1 -> done_o pulse on the next cycle, sw_o stays 1, busy_o stays 0.
- start_i pulsed during busy -> ignored; completion timing unchanged (done_o at 126).
- rst_i=1 at cycle 40 of a rising transition -> sw_o=0, IDLE next cycle, no done_o.

REQ-023 Scenario (macro defined, SEED=16'hACE1): 50 rising/falling transitions -> every phase length in 1..16, and sw_o settled equal to level_i at each done_o.
